// File: rtl/proc_run_ctrl_if.sv
// ---------------------------------------------------------------------------
// proc_run_ctrl_if
//   Groups the board-side buttons and the processor-side control/debug signals
//   of the run/step/reset sequencer into one bundle.
//
//   Signals
//     btn_rst    raw push button, processor reset request (bouncy, async)
//     btn_run    raw push button, run/pause toggle
//     btn_step   raw push button, single step (only used when the sequencer
//                is built with PRC_SINGLE_STEP_EN)
//     proc_rst   active-high reset to the processor
//     proc_en    clock enable to the processor
//     state_o    sequencer state: 00 HOLD, 01 PAUSED, 10 RUN, 11 STEP
//     cycle_cnt  number of enabled processor cycles since the last HOLD
//
//   Modports
//     master     board / stimulus side: drives the buttons, observes outputs
//     slave      the sequencer itself
// ---------------------------------------------------------------------------
interface proc_run_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             btn_rst;
    logic             btn_run;
    logic             btn_step;
    logic             proc_rst;
    logic             proc_en;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] cycle_cnt;

    modport master (
        output btn_rst,
        output btn_run,
        output btn_step,
        input  proc_rst,
        input  proc_en,
        input  state_o,
        input  cycle_cnt
    );

    modport slave (
        input  btn_rst,
        input  btn_run,
        input  btn_step,
        output proc_rst,
        output proc_en,
        output state_o,
        output cycle_cnt
    );
endinterface

// File: rtl/proc_run_ctrl.sv
// ---------------------------------------------------------------------------
// proc_run_ctrl
//   Run/step/reset sequencer for the processor core on the board top. Turns the
//   raw push buttons into a clean processor reset and clock enable, and exposes
//   the sequencer state and an enabled-cycle counter for LEDs/debug.
//
//   Ports
//     clk0   in   system clock
//     rst0   in   asynchronous, active-low reset (clears everything at once)
//     bus    slave modport of proc_run_ctrl_if (buttons in, proc_rst/proc_en/
//            state_o/cycle_cnt out)
//
//   Parameters
//     DEBOUNCE_CYCLES  equal synchronized samples before a new button level
//                      is accepted
//     RST_HOLD_CYCLES  cycles proc_rst stays high after the debounced reset
//                      request is released
//     CNT_W            width of cycle_cnt (must match the interface)
//
//   Build option
//     PRC_SINGLE_STEP_EN  when defined, the btn_step path and the STEP state
//                         are built. When undefined, btn_step is ignored, the
//                         STEP state is unreachable and PAUSED is left only by
//                         a run pulse or a reset.
//
//   Button path: 2-flop synchronizer -> debounce counter -> rising-edge pulse.
//   Raw press to pulse is 2 + DEBOUNCE_CYCLES + 1 cycles, pulse to state change
//   one more cycle. The reset button is used as a debounced level, not a pulse.
// ---------------------------------------------------------------------------
module proc_run_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int RST_HOLD_CYCLES = 16,
    parameter int CNT_W           = 32
) (
    input  logic                  clk0,
    input  logic                  rst0,
    proc_run_ctrl_if.slave        bus
);

    // Button indices inside the per-button vectors.
    localparam int B_RST  = 0;
    localparam int B_RUN  = 1;
`ifdef PRC_SINGLE_STEP_EN
    localparam int B_STEP = 2;
    localparam int NB     = 3;
`else
    localparam int NB     = 2;
`endif

    localparam int                DB_W      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam int                HOLD_W    = $clog2(RST_HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_HOLD   = 2'b00,
        S_PAUSED = 2'b01,
        S_RUN    = 2'b10,
        S_STEP   = 2'b11
    } state_t;

    // -----------------------------------------------------------------------
    // Button input path
    // -----------------------------------------------------------------------
    logic [NB-1:0]   raw_btn;
    logic [NB-1:0]   sync1_q;
    logic [NB-1:0]   sync2_q;
    logic [NB-1:0]   deb_q;
    logic [DB_W-1:0] db_cnt_q [NB];

    // Edge detection is only needed for the pulse buttons (run, step).
    logic [NB-1:1]   deb_prev_q;
    logic [NB-1:1]   pulse_q;

`ifdef PRC_SINGLE_STEP_EN
    assign raw_btn = {bus.btn_step, bus.btn_run, bus.btn_rst};
`else
    assign raw_btn = {bus.btn_run, bus.btn_rst};

    // btn_step has no logic behind it in this build.
    logic unused_btn_step;
    assign unused_btn_step = bus.btn_step;
`endif

    always_ff @(posedge clk0 or negedge rst0) begin
        if (!rst0) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            pulse_q    <= '0;
            for (int b = 0; b < NB; b++) begin
                db_cnt_q[b] <= '0;
            end
        end else begin
            sync1_q <= raw_btn;
            sync2_q <= sync1_q;

            // The counter only advances while the synchronized sample differs
            // from the accepted level; any sample equal to the accepted level
            // (i.e. a bounce back) reloads it.
            for (int b = 0; b < NB; b++) begin
                if (sync2_q[b] == deb_q[b]) begin
                    db_cnt_q[b] <= '0;
                end else if (db_cnt_q[b] == DB_LAST) begin
                    deb_q[b]    <= sync2_q[b];
                    db_cnt_q[b] <= '0;
                end else begin
                    db_cnt_q[b] <= db_cnt_q[b] + DB_W'(1);
                end
            end

            // Registered rising edge: one pulse per accepted press, none on release.
            deb_prev_q <= deb_q[NB-1:1];
            pulse_q    <= deb_q[NB-1:1] & ~deb_prev_q;
        end
    end

    logic rst_lvl;
    logic run_pulse;
    logic step_pulse;

    assign rst_lvl   = deb_q[B_RST];
    assign run_pulse = pulse_q[B_RUN];
`ifdef PRC_SINGLE_STEP_EN
    assign step_pulse = pulse_q[B_STEP];
`else
    assign step_pulse = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Sequencer FSM, hold counter and enabled-cycle counter
    // -----------------------------------------------------------------------
    state_t            state_q,    state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0]  cyc_cnt_q,  cyc_cnt_d;
    logic              proc_rst_q;
    logic              proc_en_q;

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = '0;

        if (rst_lvl) begin
            // Reset request overrides everything and keeps the hold counter reloaded.
            state_d = S_HOLD;
        end else begin
            case (state_q)
                S_HOLD: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_d = S_PAUSED;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
                end
                S_PAUSED: begin
                    // Run wins over step when both arrive together.
                    if (run_pulse) begin
                        state_d = S_RUN;
                    end else if (step_pulse) begin
                        state_d = S_STEP;
                    end
                end
                S_RUN: begin
                    if (run_pulse) begin
                        state_d = S_PAUSED;
                    end
                end
                S_STEP: begin
                    state_d = S_PAUSED;
                end
                default: begin
                    state_d = S_HOLD;
                end
            endcase
        end
    end

    // The counter clears on the same edge that enters HOLD, and counts the
    // cycle that just completed with proc_en high (wraps silently).
    always_comb begin
        cyc_cnt_d = cyc_cnt_q;
        if (state_d == S_HOLD) begin
            cyc_cnt_d = '0;
        end else if (proc_en_q) begin
            cyc_cnt_d = cyc_cnt_q + CNT_W'(1);
        end
    end

    // Outputs are registered from the next state, so they change in lockstep
    // with state_q and never glitch.
    always_ff @(posedge clk0 or negedge rst0) begin
        if (!rst0) begin
            state_q    <= S_HOLD;
            hold_cnt_q <= '0;
            cyc_cnt_q  <= '0;
            proc_rst_q <= 1'b1;
            proc_en_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            cyc_cnt_q  <= cyc_cnt_d;
            proc_rst_q <= (state_d == S_HOLD);
            proc_en_q  <= (state_d == S_RUN) || (state_d == S_STEP);
        end
    end

    assign bus.proc_rst  = proc_rst_q;
    assign bus.proc_en   = proc_en_q;
    assign bus.state_o   = state_q;
    assign bus.cycle_cnt = cyc_cnt_q;

endmodule

// File: tb/tb_proc_run_ctrl.sv
// ---------------------------------------------------------------------------
// tb_proc_run_ctrl
//   Directed bench for proc_run_ctrl with DEBOUNCE_CYCLES=4, RST_HOLD_CYCLES=3,
//   CNT_W=4. The stimulus process queues the expected outputs for specific
//   cycles; a separate monitor compares them on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_proc_run_ctrl;

    localparam logic [1:0] ST_HOLD   = 2'b00;
    localparam logic [1:0] ST_PAUSED = 2'b01;
    localparam logic [1:0] ST_RUN    = 2'b10;
    localparam logic [1:0] ST_STEP   = 2'b11;

    logic clk;
    logic rst0;
    int   cyc = 0;

    proc_run_ctrl_if #(.CNT_W(4)) bus ();

    proc_run_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .RST_HOLD_CYCLES (3),
        .CNT_W           (4)
    ) dut (
        .clk0 (clk),
        .rst0 (rst0),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        logic [1:0] st;
        logic       r;
        logic       en;
        logic [3:0] cnt;
        string      nm;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Anchor of the current run interval for computing the running count.
    int rb = 0;
    int rc = 0;

    function automatic void push(input int d, input logic [1:0] st, input logic r,
                                 input logic en, input int cnt, input string nm);
        exp_t e;
        e.at  = cyc + d;
        e.st  = st;
        e.r   = r;
        e.en  = en;
        e.cnt = cnt[3:0];
        e.nm  = nm;
        sb.push_back(e);
    endfunction

    function automatic int cntat(input int c);
        return (rc + c - rb) & 15;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: compares every queued expectation due this cycle; an entry whose
    // cycle has passed without being compared is reported as a failure.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at == cyc) begin
                n_cmp++;
                if (bus.state_o !== sb[i].st || bus.proc_rst !== sb[i].r ||
                    bus.proc_en !== sb[i].en || bus.cycle_cnt !== sb[i].cnt) begin
                    n_bad++;
                    $display("FAIL %s @cyc %0d: got st=%b rst=%b en=%b cnt=%0d, want st=%b rst=%b en=%b cnt=%0d",
                             sb[i].nm, cyc, bus.state_o, bus.proc_rst, bus.proc_en, bus.cycle_cnt,
                             sb[i].st, sb[i].r, sb[i].en, sb[i].cnt);
                end
                sb.delete(i);
            end else if (sb[i].at < cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s: expectation for cyc %0d never compared (now %0d)",
                         sb[i].nm, sb[i].at, cyc);
                sb.delete(i);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got time %0t, required < 200000", $time);
        $fatal(1);
    end

    initial begin
        int base;
        int ecnt;

        bus.btn_rst  = 1'b0;
        bus.btn_run  = 1'b0;
        bus.btn_step = 1'b0;
        rst0         = 1'b1;
        #1 rst0      = 1'b0;

        // Power-on reset, then exactly 3 HOLD cycles before PAUSED.
        tick(2);
        push(0, ST_HOLD, 1'b1, 1'b0, 0, "in_reset");
        tick(3);
        rst0 = 1'b1;
        push(0, ST_HOLD,   1'b1, 1'b0, 0, "hold_c0");
        push(1, ST_HOLD,   1'b1, 1'b0, 0, "hold_c1");
        push(2, ST_HOLD,   1'b1, 1'b0, 0, "hold_c2");
        push(3, ST_PAUSED, 1'b0, 1'b0, 0, "hold_to_paused");
        tick(6);

        // Run press: RUN 8 cycles after press, count wraps after 16 enabled cycles.
        base = cyc;
        bus.btn_run = 1'b1;
        push(7,  ST_PAUSED, 1'b0, 1'b0, 0,  "run_not_yet");
        push(8,  ST_RUN,    1'b0, 1'b1, 0,  "run_enter");
        push(9,  ST_RUN,    1'b0, 1'b1, 1,  "run_cnt1");
        push(23, ST_RUN,    1'b0, 1'b1, 15, "run_cnt15");
        push(24, ST_RUN,    1'b0, 1'b1, 0,  "run_wrap");
        tick(10);
        bus.btn_run = 1'b0;
        tick(20);

        // Second press pauses; count frozen.
        push(7,  ST_RUN,    1'b0, 1'b1, 13, "pause_not_yet");
        push(8,  ST_PAUSED, 1'b0, 1'b0, 14, "pause_enter");
        push(12, ST_PAUSED, 1'b0, 1'b0, 14, "pause_frozen");
        bus.btn_run = 1'b1;
        tick(10);
        bus.btn_run = 1'b0;
        tick(20);

        // Bouncing run button never settles: no pulse.
        push(4,  ST_PAUSED, 1'b0, 1'b0, 14, "bounce_a");
        push(10, ST_PAUSED, 1'b0, 1'b0, 14, "bounce_b");
        push(16, ST_PAUSED, 1'b0, 1'b0, 14, "bounce_c");
        push(22, ST_PAUSED, 1'b0, 1'b0, 14, "bounce_d");
        push(28, ST_PAUSED, 1'b0, 1'b0, 14, "bounce_e");
        for (int i = 0; i < 20; i++) begin
            bus.btn_run = (((i / 2) % 2) == 0);
            tick(1);
        end
        bus.btn_run = 1'b0;
        tick(10);

        // Step press in PAUSED.
        ecnt = 14;
        push(7, ST_PAUSED, 1'b0, 1'b0, ecnt, "step_not_yet");
`ifdef PRC_SINGLE_STEP_EN
        push(8, ST_STEP,   1'b0, 1'b1, ecnt,     "step_enter");
        push(9, ST_PAUSED, 1'b0, 1'b0, ecnt + 1, "step_done");
        ecnt = ecnt + 1;
`else
        push(8, ST_PAUSED, 1'b0, 1'b0, ecnt, "step_ignored_a");
        push(9, ST_PAUSED, 1'b0, 1'b0, ecnt, "step_ignored_b");
`endif
        bus.btn_step = 1'b1;
        tick(10);
        bus.btn_step = 1'b0;
        tick(20);

        // Run and step in the same cycle: run wins.
        base = cyc;
        rb   = base + 8;
        rc   = ecnt;
        push(7, ST_PAUSED, 1'b0, 1'b0, ecnt, "runstep_not_yet");
        push(8, ST_RUN,    1'b0, 1'b1, ecnt, "runstep_run");
        push(9, ST_RUN,    1'b0, 1'b1, cntat(base + 9), "runstep_cnt");
        bus.btn_run  = 1'b1;
        bus.btn_step = 1'b1;
        tick(10);
        bus.btn_run  = 1'b0;
        bus.btn_step = 1'b0;
        tick(20);

        // Step in RUN is ignored.
        base = cyc;
        push(8, ST_RUN, 1'b0, 1'b1, cntat(base + 8), "step_in_run_a");
        push(9, ST_RUN, 1'b0, 1'b1, cntat(base + 9), "step_in_run_b");
        bus.btn_step = 1'b1;
        tick(10);
        bus.btn_step = 1'b0;
        tick(20);

        // Reset button held 50 cycles during RUN.
        base = cyc;
        push(6,  ST_RUN,  1'b0, 1'b1, cntat(base + 6), "btnrst_not_yet");
        push(7,  ST_HOLD, 1'b1, 1'b0, 0, "btnrst_hold");
        push(30, ST_HOLD, 1'b1, 1'b0, 0, "btnrst_held");
        bus.btn_rst = 1'b1;
        tick(50);
        bus.btn_rst = 1'b0;
        push(8,  ST_HOLD,   1'b1, 1'b0, 0, "btnrst_rel_hold");
        push(9,  ST_PAUSED, 1'b0, 1'b0, 0, "btnrst_rel_paused");
        push(12, ST_PAUSED, 1'b0, 1'b0, 0, "btnrst_rel_stay");
        tick(15);

        // Asynchronous rst0 mid-RUN, asserted between clock edges.
        base = cyc;
        push(8,  ST_RUN, 1'b0, 1'b1, 0, "arst_run");
        push(14, ST_RUN, 1'b0, 1'b1, 6, "arst_before");
        bus.btn_run = 1'b1;
        tick(10);
        bus.btn_run = 1'b0;
        tick(5);
        rst0 = 1'b0;
        push(0, ST_HOLD, 1'b1, 1'b0, 0, "arst_immediate");
        tick(3);
        rst0 = 1'b1;
        push(2, ST_HOLD,   1'b1, 1'b0, 0, "arst_rel_hold");
        push(3, ST_PAUSED, 1'b0, 1'b0, 0, "arst_rel_paused");
        tick(10);

        for (int i = 0; i < 20 && sb.size() != 0; i++) tick(1);
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending expectations, required 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
